// File: rtl/mmsc_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package   : mmsc_pkg                                             |
// | Purpose   : Mode encodings and types shared by the multi-mode    |
// |             step counter and its next-value datapath.            |
// | Revision  : 1.0  initial release                                 |
// +------------------------------------------------------------------+
package mmsc_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_PINGPONG = 2'b00;
    localparam mode_t MODE_UPWRAP   = 2'b01;
    localparam mode_t MODE_DOWNWRAP = 2'b10;
    localparam mode_t MODE_HOLD     = 2'b11;

endpackage
`default_nettype wire

// File: rtl/mmsc_next_value.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module    : mmsc_next_value                                      |
// | Purpose   : Combinational mode action for the step counter:      |
// |             given the current value, direction and range, works  |
// |             out the next value, next direction and wrap/reversal |
// |             event. Assumes a valid range with out inside it.     |
// | Revision  : 1.0  initial release                                 |
// +------------------------------------------------------------------+
module mmsc_next_value
    import mmsc_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] cur_i,
    input  logic             dir_i,
    input  logic             flip_i,
    input  mode_t            mode_i,
    input  logic [WIDTH-1:0] min_i,
    input  logic [WIDTH-1:0] max_i,
    input  logic [WIDTH-1:0] step_i,
    output logic [WIDTH-1:0] nxt_o,
    output logic             dir_o,
    output logic             evt_o
);

    // One extra bit on sums so that out+step and min+step never wrap.
    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_lo_plus;
    logic           w_dir_eff;

    assign w_sum     = {1'b0, cur_i} + {1'b0, step_i};
    assign w_lo_plus = {1'b0, min_i} + {1'b0, step_i};
    assign w_dir_eff = flip_i ? ~dir_i : dir_i;

    // Per-mode next value, direction and boundary event.
    always_comb begin
        nxt_o = cur_i;
        dir_o = dir_i;
        evt_o = 1'b0;
        case (mode_i)
            MODE_PINGPONG: begin
                if (step_i == '0) begin
                    // Zero step never moves the value; flip still turns around.
                    dir_o = w_dir_eff;
                end else if (w_dir_eff) begin
                    if (w_sum >= {1'b0, max_i}) begin
                        nxt_o = max_i;
                        dir_o = 1'b0;
                        evt_o = 1'b1;
                    end else begin
                        nxt_o = w_sum[WIDTH-1:0];
                        dir_o = 1'b1;
                    end
                end else begin
                    // out-step <= min rewritten as out <= min+step to avoid underflow.
                    if ({1'b0, cur_i} <= w_lo_plus) begin
                        nxt_o = min_i;
                        dir_o = 1'b1;
                        evt_o = 1'b1;
                    end else begin
                        nxt_o = cur_i - step_i;
                        dir_o = 1'b0;
                    end
                end
            end
            MODE_UPWRAP: begin
                dir_o = 1'b1;
                if (w_sum > {1'b0, max_i}) begin
                    nxt_o = min_i;
                    evt_o = 1'b1;
                end else begin
                    nxt_o = w_sum[WIDTH-1:0];
                end
            end
            MODE_DOWNWRAP: begin
                dir_o = 1'b0;
                if ({1'b0, cur_i} < w_lo_plus) begin
                    nxt_o = max_i;
                    evt_o = 1'b1;
                end else begin
                    nxt_o = cur_i - step_i;
                end
            end
            default: begin
                nxt_o = cur_i;
                dir_o = dir_i;
                evt_o = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multi_mode_step_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module    : multi_mode_step_counter                              |
// | Purpose   : Programmable-step counter with ping-pong, up-wrap,   |
// |             down-wrap and hold modes, synchronous load and a     |
// |             registered boundary-event pulse.                     |
// | Options   : EVENT_COUNT_EN adds a saturating event_cnt output.   |
// | Revision  : 1.0  initial release                                 |
// +------------------------------------------------------------------+
module multi_mode_step_counter
    import mmsc_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             flip,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] min,
    input  logic [WIDTH-1:0] max,
    input  logic [WIDTH-1:0] step,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             direction,
    output logic [WIDTH-1:0] out,
    output logic             evt
`ifdef EVENT_COUNT_EN
    ,
    output logic [CNT_W-1:0] event_cnt
`endif
);

    // Reject a degenerate counter width at elaboration.
    if (CNT_W < 1) begin : g_cnt_w_check
        $error("CNT_W must be at least 1");
    end

    logic [WIDTH-1:0] out_q, out_d;
    logic             dir_q, dir_d;
    logic             evt_q, evt_d;

    logic [WIDTH-1:0] w_mode_nxt;
    logic             w_mode_dir;
    logic             w_mode_evt;
    logic             w_load_ok;
    logic             w_range_ok;
    logic             w_in_range;

    assign w_load_ok  = (load_val >= min) && (load_val <= max);
    assign w_range_ok = (max > min);
    assign w_in_range = (out_q >= min) && (out_q <= max);

    mmsc_next_value #(
        .WIDTH (WIDTH)
    ) u_next (
        .cur_i  (out_q),
        .dir_i  (dir_q),
        .flip_i (flip),
        .mode_i (mode),
        .min_i  (min),
        .max_i  (max),
        .step_i (step),
        .nxt_o  (w_mode_nxt),
        .dir_o  (w_mode_dir),
        .evt_o  (w_mode_evt)
    );

    // Priority chain: load, enable, range validity, recovery, then mode action.
    always_comb begin
        out_d = out_q;
        dir_d = dir_q;
        evt_d = 1'b0;
        if (load) begin
            if (w_load_ok) begin
                out_d = load_val;
            end
        end else if (!enable) begin
            out_d = out_q;
        end else if (!w_range_ok) begin
            out_d = out_q;
        end else if (!w_in_range) begin
            out_d = min;
            dir_d = 1'b1;
        end else begin
            out_d = w_mode_nxt;
            dir_d = w_mode_dir;
            evt_d = w_mode_evt;
        end
    end

    // State registers; reset restarts at the live min going up.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q <= min;
            dir_q <= 1'b1;
            evt_q <= 1'b0;
        end else begin
            out_q <= out_d;
            dir_q <= dir_d;
            evt_q <= evt_d;
        end
    end

    assign out       = out_q;
    assign direction = dir_q;
    assign evt       = evt_q;

`ifdef EVENT_COUNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Saturating tally of evt pulses, cleared by reset or any load request.
    always_ff @(posedge clk) begin
        if (!rst_n || load) begin
            cnt_q <= '0;
        end else if (evt_d && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign event_cnt = cnt_q;
`endif

endmodule
`default_nettype wire
